// File: rtl/io_link_pkg.sv
// Shared link codes and receiver state type for the software-to-hardware byte link.
// IO_RX_CSUM_EN adds the checksum states to io_rx_state_t.
package io_link_pkg;

  localparam logic [1:0] SIG_IDLE    = 2'd0;
  localparam logic [1:0] SIG_STROBE  = 2'd1;
  localparam logic [1:0] SIG_ACK     = 2'd2;
  localparam logic [1:0] SIG_ABORT   = 2'd3;

  localparam logic [1:0] HW_READY    = 2'd0;
  localparam logic [1:0] HW_TAKEN    = 2'd1;
  localparam logic [1:0] HW_BUSY     = 2'd2;
  localparam logic [1:0] HW_CSUM_ERR = 2'd3;

`ifdef IO_RX_CSUM_EN
  typedef enum logic [2:0] {
    ST_IDLE, ST_READ, ST_ACK, ST_COMMIT, ST_DRAW, ST_CSUM_WAIT, ST_CSUM_RD, ST_ERR
  } io_rx_state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE, ST_READ, ST_ACK, ST_COMMIT, ST_DRAW
  } io_rx_state_t;
`endif

  function automatic logic [1:0] sw_code(input io_rx_state_t s);
    case (s)
      ST_READ: sw_code = HW_TAKEN;
      ST_DRAW: sw_code = HW_BUSY;
`ifdef IO_RX_CSUM_EN
      ST_CSUM_RD: sw_code = HW_TAKEN;
      ST_ERR:     sw_code = HW_CSUM_ERR;
`endif
      default: sw_code = HW_READY;
    endcase
  endfunction

endpackage

// File: rtl/io_rec_packer.sv
// Byte-to-record shift register; first byte in ends up as the record MSB.
module io_rec_packer #(
  parameter int BYTES_PER_REC = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       shift_en,
  input  logic                       clr,
  input  logic [7:0]                 byte_in,
  output logic                       last_byte,
  output logic [8*BYTES_PER_REC-1:0] rec
);

  localparam int RW = 8 * BYTES_PER_REC;
  localparam int CW = $clog2(BYTES_PER_REC + 1);

  // byte_idx counts bytes captured so far in the current record
  logic [CW-1:0] byte_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rec      <= '0;
      byte_idx <= '0;
    end else if (clr) begin
      byte_idx <= '0;
    end else if (shift_en) begin
      rec      <= (rec << 8) | RW'(byte_in);
      byte_idx <= byte_idx + CW'(1);
    end
  end

  assign last_byte = (byte_idx == CW'(BYTES_PER_REC));

endmodule

// File: rtl/io_frame_rx.sv
// Frame receiver: packs link bytes into records, writes them to RAM, then hands off to drawing.
// Define IO_RX_CSUM_EN to require a trailing XOR checksum byte per frame.
module io_frame_rx
  import io_link_pkg::*;
#(
  parameter int BYTES_PER_REC = 3,
  parameter int NUM_REC       = 32,
  parameter int ADDR_W        = $clog2(NUM_REC)
) (
  input  logic                       clk50,
  input  logic                       reset,
  input  logic [7:0]                 to_hw_data,
  input  logic [1:0]                 to_hw_sig,
  output logic [1:0]                 to_sw_sig,
  input  logic                       finish_draw,
  output logic                       ram_we,
  output logic [ADDR_W-1:0]          ram_addr,
  output logic [8*BYTES_PER_REC-1:0] ram_wdata,
  output logic                       frame_ready
);

  localparam logic [ADDR_W-1:0] LAST_REC = ADDR_W'(NUM_REC - 1);

  io_rx_state_t      state;
  logic [ADDR_W-1:0] rec_idx;
  logic              last_byte;
  logic              shift_en;
  logic              abort_hit;
  logic              pack_clr;
  logic [8*BYTES_PER_REC-1:0] rec;

  assign shift_en = (to_hw_sig == SIG_STROBE) && (state == ST_IDLE || state == ST_ACK);

  always_comb begin
    abort_hit = 1'b0;
    if (to_hw_sig == SIG_ABORT) begin
      if (state == ST_IDLE || state == ST_READ || state == ST_ACK)
        abort_hit = 1'b1;
`ifdef IO_RX_CSUM_EN
      if (state == ST_CSUM_WAIT || state == ST_CSUM_RD)
        abort_hit = 1'b1;
`endif
    end
  end

  assign pack_clr = abort_hit || (state == ST_COMMIT);

  io_rec_packer #(.BYTES_PER_REC(BYTES_PER_REC)) u_packer (
    .clk       (clk50),
    .reset     (reset),
    .shift_en  (shift_en),
    .clr       (pack_clr),
    .byte_in   (to_hw_data),
    .last_byte (last_byte),
    .rec       (rec)
  );

`ifdef IO_RX_CSUM_EN
  // Folding the checksum byte into the running XOR means a match leaves zero.
  logic [7:0] csum;
  logic       csum_take;
  assign csum_take = (state == ST_CSUM_WAIT) && (to_hw_sig == SIG_STROBE);

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset)                       csum <= '0;
    else if (abort_hit)              csum <= '0;
    else if (state == ST_IDLE)       csum <= shift_en ? to_hw_data : 8'h00;
    else if (shift_en || csum_take)  csum <= csum ^ to_hw_data;
  end
`endif

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      rec_idx <= '0;
    end else if (abort_hit) begin
      state   <= ST_IDLE;
      rec_idx <= '0;
    end else begin
      case (state)
        ST_IDLE: if (to_hw_sig == SIG_STROBE) state <= ST_READ;
        ST_READ: if (to_hw_sig == SIG_ACK) state <= last_byte ? ST_COMMIT : ST_ACK;
        ST_ACK:  if (to_hw_sig == SIG_STROBE) state <= ST_READ;
        ST_COMMIT: begin
          if (rec_idx == LAST_REC) begin
`ifdef IO_RX_CSUM_EN
            state <= ST_CSUM_WAIT;
`else
            state <= ST_DRAW;
`endif
          end else begin
            rec_idx <= rec_idx + ADDR_W'(1);
            state   <= ST_ACK;
          end
        end
        ST_DRAW: begin
          if (finish_draw) begin
            state   <= ST_IDLE;
            rec_idx <= '0;
          end
        end
`ifdef IO_RX_CSUM_EN
        ST_CSUM_WAIT: if (to_hw_sig == SIG_STROBE) state <= ST_CSUM_RD;
        ST_CSUM_RD:   if (to_hw_sig == SIG_ACK) state <= (csum == 8'h00) ? ST_DRAW : ST_ERR;
        ST_ERR: begin
          if (to_hw_sig == SIG_IDLE) begin
            state   <= ST_IDLE;
            rec_idx <= '0;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign to_sw_sig   = sw_code(state);
  assign frame_ready = (state == ST_DRAW);
  assign ram_we      = (state == ST_COMMIT);
  assign ram_addr    = rec_idx;
  assign ram_wdata   = rec;

endmodule

// File: tb/tb_io_frame_rx.sv
// Scoreboard bench for io_frame_rx: a byte-list frame model predicts each RAM write.
module tb_io_frame_rx;

  localparam int BPR  = 3;
  localparam int NREC = 32;
  localparam int AW   = 5;
  localparam int NB   = BPR * NREC;
  localparam int RW   = 8 * BPR;

  logic          clk50 = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    to_hw_data = 8'h00;
  logic [1:0]    to_hw_sig = 2'd0;
  logic          finish_draw = 1'b0;
  logic [1:0]    to_sw_sig;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [RW-1:0] ram_wdata;
  logic          frame_ready;

  io_frame_rx #(.BYTES_PER_REC(BPR), .NUM_REC(NREC), .ADDR_W(AW)) dut (
    .clk50       (clk50),
    .reset       (reset),
    .to_hw_data  (to_hw_data),
    .to_hw_sig   (to_hw_sig),
    .to_sw_sig   (to_sw_sig),
    .finish_draw (finish_draw),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .frame_ready (frame_ready)
  );

  always #5 clk50 = ~clk50;

  int checks = 0;
  int fails  = 0;

  logic [7:0]    fb [NB];
  logic [AW-1:0] exp_addr_q [$];
  logic [RW-1:0] exp_data_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every write strobe must match the next predicted record.
  always @(negedge clk50) begin
    if (!reset && ram_we) begin
      if (exp_addr_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_write: addr %0d data 0x%06h, expected no write", ram_addr, ram_wdata);
      end else begin
        $display("write addr %0d data 0x%06h", ram_addr, ram_wdata);
        check("write_addr", 32'(ram_addr), 32'(exp_addr_q.pop_front()));
        check("write_data", 32'(ram_wdata), 32'(exp_data_q.pop_front()));
      end
    end
  end

  task automatic wait_sw(input logic [1:0] v, input string name);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk50); #1;
      if (to_sw_sig == v) return;
    end
    checks++;
    fails++;
    $display("FAIL %s timeout: to_sw_sig=%0d, expected %0d", name, to_sw_sig, v);
  endtask

  // Leaves to_hw_sig at ack, sampled one cycle after the ack edge.
  task automatic send_byte(input logic [7:0] b, input bit hold);
    if ($urandom_range(0, 3) == 0) begin
      to_hw_sig = 2'd0;
      @(posedge clk50); #1;
    end
    wait_sw(2'd0, "wait_ready");
    to_hw_data = b;
    to_hw_sig  = 2'd1;
    wait_sw(2'd1, "wait_taken");
    if (hold) begin
      repeat (10) begin @(posedge clk50); #1; end
      check("hold_read_sw", 32'(to_sw_sig), 32'd1);
    end
    to_hw_data = 8'($urandom);
    repeat ($urandom_range(0, 2)) begin
      to_hw_sig = 2'd0;
      @(posedge clk50); #1;
    end
    to_hw_sig = 2'd2;
    @(posedge clk50); #1;
  endtask

  task automatic send_frame(input int stop_at, input bit use_reset, input int hold_at, input bit csum_good);
    logic [RW-1:0] r;
    logic [7:0]    x;
    x = 8'h00;
    for (int i = 0; i < stop_at; i++) begin
      x ^= fb[i];
      if (i % BPR == BPR - 1) begin
        r = '0;
        for (int j = 0; j < BPR; j++) r = (r << 8) | RW'(fb[i - BPR + 1 + j]);
        exp_addr_q.push_back(AW'(i / BPR));
        exp_data_q.push_back(r);
      end
      send_byte(fb[i], i == hold_at);
    end
    if (stop_at < NB) begin
      if (use_reset) begin
        reset = 1'b1;
        #1;
        check("rst_mid_sw", 32'(to_sw_sig), 32'd0);
        check("rst_mid_we", 32'(ram_we), 32'd0);
        check("rst_mid_addr", 32'(ram_addr), 32'd0);
        check("rst_mid_wdata", 32'(ram_wdata), 32'd0);
        check("rst_mid_ready", 32'(frame_ready), 32'd0);
        to_hw_sig = 2'd0;
        @(posedge clk50); #1;
        reset = 1'b0;
        $display("frame reset after %0d bytes", stop_at);
      end else begin
        to_hw_sig = 2'd3;
        @(posedge clk50); #1;
        check("abort_sw", 32'(to_sw_sig), 32'd0);
        check("abort_we", 32'(ram_we), 32'd0);
        to_hw_sig = 2'd0;
        $display("frame aborted after %0d bytes", stop_at);
      end
      return;
    end
    check("commit_we", 32'(ram_we), 32'd1);
    check("commit_ready", 32'(frame_ready), 32'd0);
`ifdef IO_RX_CSUM_EN
    @(posedge clk50); #1;
    check("csum_wait_sw", 32'(to_sw_sig), 32'd0);
    send_byte(csum_good ? x : 8'h00, 1'b0);
    if (!csum_good) begin
      check("csum_err_sw", 32'(to_sw_sig), 32'd3);
      repeat (3) begin @(posedge clk50); #1; end
      check("csum_err_hold", 32'(to_sw_sig), 32'd3);
      check("csum_err_ready", 32'(frame_ready), 32'd0);
      to_hw_sig = 2'd0;
      @(posedge clk50); #1;
      check("csum_err_exit", 32'(to_sw_sig), 32'd0);
      $display("frame checksum rejected (sent 0x00, frame xor 0x%02h)", x);
      return;
    end
`else
    @(posedge clk50); #1;
`endif
    check("draw_ready", 32'(frame_ready), 32'd1);
    check("draw_sw", 32'(to_sw_sig), 32'd2);
    repeat ($urandom_range(1, 4)) begin
      to_hw_sig = 2'($urandom);
      @(posedge clk50); #1;
    end
    check("draw_hold_ready", 32'(frame_ready), 32'd1);
    to_hw_sig   = 2'd0;
    finish_draw = 1'b1;
    @(posedge clk50); #1;
    finish_draw = 1'b0;
    check("finish_sw", 32'(to_sw_sig), 32'd0);
    check("finish_ready", 32'(frame_ready), 32'd0);
    $display("frame complete (xor 0x%02h)", x);
  endtask

  task automatic fill_pattern();
    for (int k = 0; k < NREC; k++)
      for (int j = 0; j < BPR; j++)
        fb[k * BPR + j] = 8'(8'h11 * (j + 1) + k);
  endtask

  task automatic fill_random();
    for (int i = 0; i < NB; i++) fb[i] = 8'($urandom);
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) begin @(posedge clk50); #1; end
    check("rst_sw", 32'(to_sw_sig), 32'd0);
    check("rst_we", 32'(ram_we), 32'd0);
    check("rst_addr", 32'(ram_addr), 32'd0);
    check("rst_wdata", 32'(ram_wdata), 32'd0);
    check("rst_ready", 32'(frame_ready), 32'd0);
    reset = 1'b0;
    @(posedge clk50); #1;

    finish_draw = 1'b1;
    @(posedge clk50); #1;
    finish_draw = 1'b0;
    check("idle_finish_sw", 32'(to_sw_sig), 32'd0);
    check("idle_finish_ready", 32'(frame_ready), 32'd0);

    fill_pattern();
    send_frame(NB, 1'b0, -1, 1'b1);

    fill_random();
    send_frame(5 * BPR + 2, 1'b0, -1, 1'b1);
    fill_random();
    send_frame(NB, 1'b0, int'($urandom_range(0, NB - 1)), 1'b1);

    fill_random();
    send_frame(3 * BPR + 1, 1'b1, -1, 1'b1);
    fill_random();
    send_frame(NB, 1'b0, -1, 1'b1);

`ifdef IO_RX_CSUM_EN
    begin
      logic [7:0] x;
      fill_random();
      x = 8'h00;
      for (int i = 0; i < NB; i++) x ^= fb[i];
      fb[NB - 1] = fb[NB - 1] ^ x ^ 8'h5A;
      send_frame(NB, 1'b0, -1, 1'b0);
      fill_random();
      send_frame(NB, 1'b0, -1, 1'b1);
    end
`endif

    repeat (3) begin @(posedge clk50); #1; end
    check("pending_writes", 32'(exp_addr_q.size()), 32'd0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
